// File: rtl/pulse_stretch_pkg.sv
// Shared bus package for the pulse stretcher.
// Holds the stretcher FSM state encoding and the default stretch length
// that bus masters drive onto len when they have no specific width in mind.
package pulse_stretch_pkg;

    typedef logic [1:0] ps_state_t;

    localparam ps_state_t S_IDLE   = 2'd0;
    localparam ps_state_t S_ACTIVE = 2'd1;
    localparam ps_state_t S_GAP    = 2'd2;

    localparam int unsigned DEF_STRETCH_LEN = 4;

endpackage

// File: rtl/pulse_stretch_pend_ctr.sv
// Saturating up/down pending-event counter with a sticky overflow flag.
// Ports:
//   clk, rstn    : clock, asynchronous active-low reset
//   inc_i        : one event arrives this cycle
//   dec_i        : one event is consumed this cycle
//   clr_ovf_i    : synchronous clear of ovf_o (a same-cycle overflow wins)
//   cnt_o        : registered count
//   cnt_next_o   : count that will be registered at the next edge
//   ovf_o        : sticky, an increment was refused because the count was full
module pulse_stretch_pend_ctr #(
    parameter int unsigned MAX_PEND = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       clr_ovf_i,
    output logic [3:0] cnt_o,
    output logic [3:0] cnt_next_o,
    output logic       ovf_o
);

    localparam logic [3:0] CntMax = 4'(MAX_PEND);

    logic [3:0] cnt_d, cnt_q;
    logic       ovf_d, ovf_q;
    logic       ovf_set;

    always_comb begin
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        // Simultaneous inc and dec cancel: the arriving event takes the freed slot.
        if (inc_i && !dec_i) begin
            if (cnt_q < CntMax) begin
                cnt_d = cnt_q + 4'd1;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (dec_i && !inc_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
        ovf_d = ovf_set | (ovf_q & ~clr_ovf_i);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 4'd0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;
    assign ovf_o      = ovf_q;

endmodule

// File: rtl/pulse_stretch.sv
// Pulse stretcher: turns single-cycle trigger pulses into high levels lasting
// len clocks (0 treated as 1). Retrigger mode extends an active stretch;
// queue mode counts triggers and replays them separated by GAP_CYC low cycles.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   din       : trigger, one event per high cycle
//   len       : stretch length, sampled when a stretch starts
//   clr_ovf   : synchronous clear of ovf
//   dout      : registered stretched level
//   busy      : stretch or gap in progress, or events pending
//   done      : one-cycle pulse after the last high cycle of each stretch
//   pend      : pending-event count (0 in retrigger mode)
//   ovf       : sticky, a trigger was dropped on a full queue
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int unsigned CW       = 8,
    parameter int unsigned RETRIG   = 0,
    parameter int unsigned MAX_PEND = 3,
    parameter int unsigned GAP_CYC  = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          din,
    input  logic [CW-1:0] len,
    input  logic          clr_ovf,
    output logic          dout,
    output logic          busy,
    output logic          done,
    output logic [3:0]    pend,
    output logic          ovf
);

    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GapLoad = GW'(GAP_CYC - 1);
    localparam bit Retrig = (RETRIG != 0);

    ps_state_t     state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [GW-1:0] gcnt_d, gcnt_q;
    logic          rflag_d, rflag_q;  // retrigger mode: trigger seen during GAP
    logic          dout_d, dout_q;
    logic          done_d, done_q;
    logic          busy_d, busy_q;

    logic [CW-1:0] len_m1;
    logic          pc_inc, pc_dec;
    logic [3:0]    pc_cnt, pc_cnt_next;
    logic          pc_ovf;

    assign len_m1 = (len == '0) ? '0 : len - CW'(1);

    pulse_stretch_pend_ctr #(
        .MAX_PEND (MAX_PEND)
    ) u_pend_ctr (
        .clk        (clk),
        .rstn       (rstn),
        .inc_i      (pc_inc),
        .dec_i      (pc_dec),
        .clr_ovf_i  (clr_ovf),
        .cnt_o      (pc_cnt),
        .cnt_next_o (pc_cnt_next),
        .ovf_o      (pc_ovf)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            rflag_q <= 1'b0;
            dout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            rflag_q <= rflag_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        rflag_d = rflag_q;
        pc_dec  = 1'b0;
        pc_inc  = !Retrig && din && (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (din) begin
                    state_d = S_ACTIVE;
                    cnt_d   = len_m1;
                end
            end
            S_ACTIVE: begin
                if (Retrig && din) begin
                    cnt_d = len_m1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = S_GAP;
                    gcnt_d  = GapLoad;
                end
            end
            S_GAP: begin
                if (Retrig && din) begin
                    rflag_d = 1'b1;
                end
                if (gcnt_q != '0) begin
                    gcnt_d = gcnt_q - GW'(1);
                end else if (Retrig ? (rflag_q || din) : ((pc_cnt != 4'd0) || din)) begin
                    // In queue mode a same-cycle din cancels the decrement in the counter.
                    state_d = S_ACTIVE;
                    cnt_d   = len_m1;
                    rflag_d = 1'b0;
                    pc_dec  = !Retrig;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic, registered alongside the state
    always_comb begin
        dout_d = (state_d == S_ACTIVE);
        done_d = (state_q == S_ACTIVE) && (state_d == S_GAP);
        busy_d = (state_d != S_IDLE) || (!Retrig && (pc_cnt_next != 4'd0)) || rflag_d;
    end

    assign dout = dout_q;
    assign done = done_q;
    assign busy = busy_q;
    assign pend = Retrig ? 4'd0 : pc_cnt;
    assign ovf  = Retrig ? 1'b0 : pc_ovf;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch. Four instances cover the parameter sets:
//   u_d default (queue, GAP 1, depth 3), u_q (GAP 2), u_r (retrigger), u_o (depth 1).
// Cycle t is the interval after the t-th rising edge since a test began;
// din is driven just after an edge and outputs are sampled on the falling edge.
module tb_pulse_stretch;

    logic       clk;
    logic       rstn;
    logic [7:0] len;
    logic       clr_ovf;

    logic       d_din, d_dout, d_busy, d_done, d_ovf;
    logic [3:0] d_pend;
    logic       q_din, q_dout, q_busy, q_done, q_ovf;
    logic [3:0] q_pend;
    logic       r_din, r_dout, r_busy, r_done, r_ovf;
    logic [3:0] r_pend;
    logic       o_din, o_dout, o_busy, o_done, o_ovf;
    logic [3:0] o_pend;

    int checks;
    int errors;

    pulse_stretch #(.CW(8), .RETRIG(0), .MAX_PEND(3), .GAP_CYC(1)) u_d (
        .clk(clk), .rstn(rstn), .din(d_din), .len(len), .clr_ovf(clr_ovf),
        .dout(d_dout), .busy(d_busy), .done(d_done), .pend(d_pend), .ovf(d_ovf)
    );
    pulse_stretch #(.CW(8), .RETRIG(0), .MAX_PEND(3), .GAP_CYC(2)) u_q (
        .clk(clk), .rstn(rstn), .din(q_din), .len(len), .clr_ovf(clr_ovf),
        .dout(q_dout), .busy(q_busy), .done(q_done), .pend(q_pend), .ovf(q_ovf)
    );
    pulse_stretch #(.CW(8), .RETRIG(1), .MAX_PEND(3), .GAP_CYC(1)) u_r (
        .clk(clk), .rstn(rstn), .din(r_din), .len(len), .clr_ovf(clr_ovf),
        .dout(r_dout), .busy(r_busy), .done(r_done), .pend(r_pend), .ovf(r_ovf)
    );
    pulse_stretch #(.CW(8), .RETRIG(0), .MAX_PEND(1), .GAP_CYC(1)) u_o (
        .clk(clk), .rstn(rstn), .din(o_din), .len(len), .clr_ovf(clr_ovf),
        .dout(o_dout), .busy(o_busy), .done(o_done), .pend(o_pend), .ovf(o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Puts all instances in reset and leaves the bench just after a rising edge.
    task automatic apply_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({d_dout, d_busy, d_done, d_ovf, d_pend} !== 8'h00) begin
            errors++;
            $display("FAIL reset_d got %b exp 00000000", {d_dout, d_busy, d_done, d_ovf, d_pend});
        end
        checks++;
        if ({r_dout, r_busy, r_done, r_ovf, r_pend} !== 8'h00) begin
            errors++;
            $display("FAIL reset_r got %b exp 00000000", {r_dout, r_busy, r_done, r_ovf, r_pend});
        end
        rstn = 1'b1;
    endtask

    // len=4, pulse at 10: dout 11-14, done 15, busy 11-15. len changes mid-stretch.
    task automatic test_length();
        logic e_dout, e_done, e_busy;
        apply_reset();
        len = 8'd4;
        for (int t = 0; t <= 20; t++) begin
            d_din = (t == 10);
            if (t == 12) len = 8'd9;
            @(negedge clk);
            e_dout = (t >= 11 && t <= 14);
            e_done = (t == 15);
            e_busy = (t >= 11 && t <= 15);
            checks++;
            if (d_dout !== e_dout) begin
                errors++;
                $display("FAIL len_dout t=%0d got %b exp %b", t, d_dout, e_dout);
            end
            checks++;
            if (d_done !== e_done) begin
                errors++;
                $display("FAIL len_done t=%0d got %b exp %b", t, d_done, e_done);
            end
            checks++;
            if (d_busy !== e_busy) begin
                errors++;
                $display("FAIL len_busy t=%0d got %b exp %b", t, d_busy, e_busy);
            end
            @(posedge clk);
            #1;
        end
        d_din = 1'b0;
    endtask

    // len=0 behaves as 1: dout at 11 only, done at 12.
    task automatic test_zero_len();
        logic e_dout, e_done;
        apply_reset();
        len = 8'd0;
        for (int t = 0; t <= 16; t++) begin
            d_din = (t == 10);
            @(negedge clk);
            e_dout = (t == 11);
            e_done = (t == 12);
            checks++;
            if (d_dout !== e_dout) begin
                errors++;
                $display("FAIL zero_dout t=%0d got %b exp %b", t, d_dout, e_dout);
            end
            checks++;
            if (d_done !== e_done) begin
                errors++;
                $display("FAIL zero_done t=%0d got %b exp %b", t, d_done, e_done);
            end
            @(posedge clk);
            #1;
        end
        d_din = 1'b0;
    endtask

    // Retrigger, len=5, pulses 10 and 13: dout 11-18, done 19, pend/ovf 0.
    task automatic test_retrigger();
        logic e_dout, e_done, e_busy;
        apply_reset();
        len = 8'd5;
        for (int t = 0; t <= 23; t++) begin
            r_din = (t == 10 || t == 13);
            @(negedge clk);
            e_dout = (t >= 11 && t <= 18);
            e_done = (t == 19);
            e_busy = (t >= 11 && t <= 19);
            checks++;
            if (r_dout !== e_dout) begin
                errors++;
                $display("FAIL retrig_dout t=%0d got %b exp %b", t, r_dout, e_dout);
            end
            checks++;
            if (r_done !== e_done) begin
                errors++;
                $display("FAIL retrig_done t=%0d got %b exp %b", t, r_done, e_done);
            end
            checks++;
            if (r_busy !== e_busy) begin
                errors++;
                $display("FAIL retrig_busy t=%0d got %b exp %b", t, r_busy, e_busy);
            end
            checks++;
            if ({r_ovf, r_pend} !== 5'd0) begin
                errors++;
                $display("FAIL retrig_ovfpend t=%0d got %b exp 00000", t, {r_ovf, r_pend});
            end
            @(posedge clk);
            #1;
        end
        r_din = 1'b0;
    endtask

    // Queue, GAP 2, len=3, pulses 10..13: stretches 11-13,16-18,21-23,26-28.
    task automatic test_queue();
        logic       e_dout, e_done, e_busy;
        logic [3:0] e_pend;
        apply_reset();
        len = 8'd3;
        for (int t = 0; t <= 33; t++) begin
            q_din = (t >= 10 && t <= 13);
            @(negedge clk);
            e_dout = (t >= 11 && t <= 13) || (t >= 16 && t <= 18) ||
                     (t >= 21 && t <= 23) || (t >= 26 && t <= 28);
            e_done = (t == 14) || (t == 19) || (t == 24) || (t == 29);
            e_busy = (t >= 11 && t <= 30);
            if (t <= 11)      e_pend = 4'd0;
            else if (t <= 13) e_pend = 4'(t - 11);
            else if (t <= 15) e_pend = 4'd3;
            else if (t <= 20) e_pend = 4'd2;
            else if (t <= 25) e_pend = 4'd1;
            else              e_pend = 4'd0;
            checks++;
            if (q_dout !== e_dout) begin
                errors++;
                $display("FAIL queue_dout t=%0d got %b exp %b", t, q_dout, e_dout);
            end
            checks++;
            if (q_done !== e_done) begin
                errors++;
                $display("FAIL queue_done t=%0d got %b exp %b", t, q_done, e_done);
            end
            checks++;
            if (q_busy !== e_busy) begin
                errors++;
                $display("FAIL queue_busy t=%0d got %b exp %b", t, q_busy, e_busy);
            end
            checks++;
            if (q_pend !== e_pend) begin
                errors++;
                $display("FAIL queue_pend t=%0d got %0d exp %0d", t, q_pend, e_pend);
            end
            checks++;
            if (q_ovf !== 1'b0) begin
                errors++;
                $display("FAIL queue_ovf t=%0d got %b exp 0", t, q_ovf);
            end
            @(posedge clk);
            #1;
        end
        q_din = 1'b0;
    endtask

    // Depth 1, len=4, pulses 10..12: pend 1 at 12-15, ovf 13-20, clr at 20.
    task automatic test_overflow();
        logic       e_dout, e_ovf;
        logic [3:0] e_pend;
        apply_reset();
        len = 8'd4;
        for (int t = 0; t <= 25; t++) begin
            o_din   = (t >= 10 && t <= 12);
            clr_ovf = (t == 20);
            @(negedge clk);
            e_dout = (t >= 11 && t <= 14) || (t >= 16 && t <= 19);
            e_ovf  = (t >= 13 && t <= 20);
            e_pend = (t >= 12 && t <= 15) ? 4'd1 : 4'd0;
            checks++;
            if (o_dout !== e_dout) begin
                errors++;
                $display("FAIL ovf_dout t=%0d got %b exp %b", t, o_dout, e_dout);
            end
            checks++;
            if (o_ovf !== e_ovf) begin
                errors++;
                $display("FAIL ovf_flag t=%0d got %b exp %b", t, o_ovf, e_ovf);
            end
            checks++;
            if (o_pend !== e_pend) begin
                errors++;
                $display("FAIL ovf_pend t=%0d got %0d exp %0d", t, o_pend, e_pend);
            end
            @(posedge clk);
            #1;
        end
        o_din   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    // len=8, pulses 10,11, reset at 13; then a fresh pulse gives a full stretch.
    task automatic test_reset_mid();
        logic e_dout, e_done;
        apply_reset();
        len = 8'd8;
        for (int t = 0; t <= 12; t++) begin
            d_din = (t == 10 || t == 11);
            @(negedge clk);
            if (t == 12) begin
                checks++;
                if ({d_dout, d_pend} !== 5'b10001) begin
                    errors++;
                    $display("FAIL mid_pre got %b exp 10001", {d_dout, d_pend});
                end
            end
            @(posedge clk);
            #1;
        end
        d_din = 1'b0;
        rstn  = 1'b0;
        #1;
        checks++;
        if ({d_dout, d_busy, d_done, d_pend} !== 7'd0) begin
            errors++;
            $display("FAIL mid_async got %b exp 0000000", {d_dout, d_busy, d_done, d_pend});
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (d_done !== 1'b0) begin
                errors++;
                $display("FAIL mid_nodone got %b exp 0", d_done);
            end
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int t = 0; t <= 14; t++) begin
            d_din = (t == 2);
            @(negedge clk);
            e_dout = (t >= 3 && t <= 10);
            e_done = (t == 11);
            checks++;
            if (d_dout !== e_dout) begin
                errors++;
                $display("FAIL mid_dout t=%0d got %b exp %b", t, d_dout, e_dout);
            end
            checks++;
            if (d_done !== e_done) begin
                errors++;
                $display("FAIL mid_done t=%0d got %b exp %b", t, d_done, e_done);
            end
            @(posedge clk);
            #1;
        end
        d_din = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rstn    = 1'b0;
        len     = 8'd0;
        clr_ovf = 1'b0;
        d_din   = 1'b0;
        q_din   = 1'b0;
        r_din   = 1'b0;
        o_din   = 1'b0;
        test_reset();
        test_length();
        test_zero_len();
        test_retrigger();
        test_queue();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_stretch.md
Name: pulse_stretch

Overview:
- Inverse of the bus edge-to-pulse converter: takes single-cycle event pulses and turns each one into a high level lasting a programmable number of clocks.
- Used on the bus side to hold request, grant and strobe lines for a fixed bus-clock width after a one-cycle trigger.
- Two modes. Retrigger mode extends the active window. Queue mode counts events and replays them, with a guaranteed low gap between them.

Parameters:
- CW, 8: width of the len input and of the internal length counter.
- RETRIG, 0: 1 = a trigger during an active stretch restarts it; 0 = the trigger is queued.
- MAX_PEND, 3: depth of the pending-event counter (queue mode only). Legal range 1..15.
- GAP_CYC, 1: minimum number of low cycles between queued stretches. Must be ≥1.

Ports:
- clk, input, 1: clock, rising edge.
- rstn, input, 1: asynchronous active-low reset.
- din, input, 1: trigger. Each clock with din=1 is one event.
- len, input, CW: stretch length in clocks. Sampled when a stretch starts. 0 is treated as 1.
- clr_ovf, input, 1: synchronous clear of ovf.
- dout, output, 1: stretched level, registered.
- busy, output, 1: high in ACTIVE or GAP, or while pend≠0.
- done, output, 1: one-cycle pulse on the cycle after the last dout-high cycle of each stretch.
- pend, output, 4: current pending-event count (always 0 when RETRIG=1).
- ovf, output, 1: sticky; a trigger was dropped because the queue was full.

Behaviour:
- Reset is rstn, asynchronous, active-low; clock is clk.
- Reset values: dout=0, busy=0, done=0, pend=0, ovf=0, state=IDLE, counters=0.
- Reset mid-stretch aborts immediately. No done pulse is produced and pending events are discarded.
- Length rule: L = (len==0) ? 1 : len, latched into cnt at stretch start. len changes during a stretch have no effect.
- FSM states: IDLE, ACTIVE, GAP.
- IDLE: din=1 at clk edge E → ACTIVE, cnt=L-1, dout=1 from edge E. Latency is 1 clock: dout is visible in the cycle after din was sampled, and stays high for exactly L cycles.
- ACTIVE with cnt>0: decrement cnt each cycle.
- ACTIVE with cnt==0 (last high cycle):
  - If RETRIG=1 and din=1: reload cnt=L-1 and stay in ACTIVE. dout stays high with no glitch.
  - Otherwise: go to GAP, dout=0, done=1 for one cycle, gap counter = GAP_CYC-1.
- RETRIG=1, din=1 in ACTIVE with any cnt: reload cnt=L-1 using the current len. No queueing, and ovf is never set.
- RETRIG=0, din=1 in ACTIVE or GAP: pend += 1 if pend<MAX_PEND; otherwise pend is unchanged and ovf=1.
- GAP: count down the gap counter. On expiry:
  - If pend>0 (including an event arriving that cycle): pend -= 1, go to ACTIVE with a fresh L, dout=1 next cycle.
  - Otherwise go to IDLE.
- GAP, RETRIG=1: din=1 starts a new stretch after the gap completes. It is held as a single pending flag (pend max 1, no ovf).
- Expiry and din on the same cycle in queue mode: the increment and decrement cancel, so pend is unchanged and the stretch starts.
- ovf: set has priority over clr_ovf in the same cycle. ovf stays set until cleared.
- busy = (state≠IDLE) | (pend≠0), registered with the state.
- Consecutive queued stretches therefore show exactly GAP_CYC low cycles between them.

Decomposition:
- Shared bus package holds:
  - the state encoding localparams S_IDLE=2'd0, S_ACTIVE=2'd1, S_GAP=2'd2;
  - the default stretch-length constant used by bus masters.
- Natural sub-module: pend_ctr, a saturating up/down counter with an overflow flag, parameterised by MAX_PEND.
- The FSM and length counter stay in pulse_stretch.

Test Plan:
- Length and latency: reset, len=4, single din pulse at cycle 10 → dout high in cycles 11-14, done=1 at cycle 15, busy low from cycle 16.
- Zero length: len=0, single pulse → dout high for exactly 1 cycle, done 1 cycle later.
- Retrigger: RETRIG=1, len=5, pulses at cycles 10 and 13 → dout high 11-18 continuously, one done at 19, ovf=0.
- Queueing: RETRIG=0, GAP_CYC=2, len=3, pulses at 10, 11, 12, 13 → stretches at 11-13, 16-18, 21-23, 26-28 with 2 low cycles between; pend peaks at 3, ovf=0.
- Overflow: MAX_PEND=1, pulses at 10, 11, 12 → pend=1, ovf=1 at cycle 13. Then clr_ovf=1 at 20 → ovf=0 at 21. Only 2 stretches produced.
- Reset mid-stretch: len=8, pulse at 10, rstn low at 13 → dout, busy and pend are 0 immediately and no done pulse. Pulse after release → normal 8-cycle stretch.
